// File: rtl/uart_rx_frame_sampler.sv
// Purpose: UART receive front end; synchronises rx_serial, finds the start bit, samples mid-bit, assembles LSB-first words.
// Latency: rx_s lags rx_serial by 2 clk; every strobe/valid/error pulse is registered and appears 1 clk after its sampling baud_tick edge.
// Backpressure: none; data_valid is a single-cycle pulse and data_out simply holds the last good word until the next one.
module uart_rx_frame_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    output logic                 bit_strobe,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] STOP       = 3'd3;
    localparam logic [2:0] BREAK_WAIT = 3'd4;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 strobe_q, strobe_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;

    // Every receive decision is taken on the second synchroniser stage only.
    assign rx_s = sync2_q;

    // Next-state logic: counters advance only on baud_tick; pulses default low so each lasts exactly one cycle.
    always_comb begin
        sync1_d    = rx_serial;
        sync2_d    = sync1_q;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        strobe_d   = 1'b0;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit after the falling edge to reject glitches.
                    if (tick_cnt_q == HALF_M1) begin
                        if (!rx_s) begin
                            strobe_d   = 1'b1;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == FULL_M1) begin
                        // Right shift: first-arriving bit ends up in bit 0.
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        strobe_d   = 1'b1;
                        tick_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == FULL_M1) begin
                        strobe_d   = 1'b1;
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            data_out_d = shift_q;
                            valid_d    = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK_WAIT;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    // A held-low line must return high before a new start can be seen.
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset; the synchroniser resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            strobe_q   <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            strobe_q   <= strobe_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bit_strobe    = strobe_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign data_out      = data_out_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Purpose: self-checking bench for uart_rx_frame_sampler; tick-indexed frame model plus directed literal checks.
// Latency: model predicts registered outputs one clk after each baud_tick sampling edge.
// Backpressure: none; stimulus drives the serial line and baud_tick freely.
module tb_uart_rx_frame_sampler;
    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk;
    logic          rst;
    logic          baud_tick;
    logic          rx_serial;
    logic          bit_strobe;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          framing_error;
    logic          busy;

    uart_rx_frame_sampler #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .rx_serial    (rx_serial),
        .bit_strobe   (bit_strobe),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .framing_error(framing_error),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;
    int tick_period = 16;
    int cyc = 0;
    int n_stb = 0, n_val = 0, n_fe = 0, n_busy = 0;
    int stb_cyc[$];
    logic [DB-1:0] vq[$];

    // Behavioural model state: frame position expressed as a tick offset from the start-detect tick.
    bit            model_on = 0;
    bit            s1, s2;
    bit            in_frame, brk;
    int            tick_idx, anchor;
    logic [DB-1:0] word, exp_dout;
    bit            e_stb, e_val, e_fe, e_busy;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Baud tick generator; the period may change between frames.
    initial begin
        int tcnt;
        tcnt = 0;
        baud_tick = 0;
        forever begin
            @(negedge clk);
            if (tcnt >= tick_period - 1) begin
                baud_tick = 1;
                tcnt = 0;
            end else begin
                baud_tick = 0;
                tcnt++;
            end
        end
    end

    // Reference model: evaluated on every rising edge from the inputs seen at that edge.
    initial begin
        forever begin
            bit rxs;
            int d, k;
            @(posedge clk);
            if (rst) begin
                s1 = 1; s2 = 1; in_frame = 0; brk = 0;
                word = '0; exp_dout = '0;
                e_stb = 0; e_val = 0; e_fe = 0; e_busy = 0;
                tick_idx = 0; anchor = 0;
                model_on = 1;
            end else begin
                rxs = s2;
                e_stb = 0; e_val = 0; e_fe = 0;
                if (baud_tick) begin
                    tick_idx++;
                    if (brk) begin
                        if (rxs) brk = 0;
                    end else if (!in_frame) begin
                        if (!rxs) begin
                            in_frame = 1;
                            anchor = tick_idx;
                        end
                    end else begin
                        d = tick_idx - anchor;
                        if (d == OS / 2) begin
                            if (rxs) in_frame = 0;
                            else     e_stb = 1;
                        end else if (d > OS / 2 && (d - OS / 2) % OS == 0) begin
                            k = (d - OS / 2) / OS;
                            e_stb = 1;
                            if (k <= DB) begin
                                word[k-1] = rxs;
                            end else begin
                                in_frame = 0;
                                if (rxs) begin
                                    exp_dout = word;
                                    e_val = 1;
                                end else begin
                                    e_fe = 1;
                                    brk = 1;
                                end
                            end
                        end
                    end
                end
                e_busy = in_frame || brk;
                s2 = s1;
                s1 = rx_serial;
            end
        end
    end

    // Compare process: every cycle after the first reset edge, all outputs against the model.
    initial begin
        forever begin
            logic [DB+3:0] got, expv;
            @(posedge clk);
            #2;
            cyc++;
            if (model_on) begin
                got  = {bit_strobe, data_valid, framing_error, busy, data_out};
                expv = {e_stb, e_val, e_fe, e_busy, exp_dout};
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL cycle_outputs cyc=%0d got{stb,val,fe,busy,dout}=%b want=%b", cyc, got, expv);
                end
                if (bit_strobe === 1'b1) begin n_stb++; stb_cyc.push_back(cyc); end
                if (data_valid === 1'b1) begin n_val++; vq.push_back(data_out); end
                if (framing_error === 1'b1) n_fe++;
                if (busy === 1'b1) n_busy++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s got=%0d expected range %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Drive one bit period; optionally pulse rst for one clk a quarter of the way in.
    task automatic send_bit(input logic b, input bit do_rst);
        int n, rst_at;
        n = OS * tick_period;
        rst_at = do_rst ? n / 4 : -1;
        rx_serial = b;
        for (int c = 0; c < n; c++) begin
            rst = (c == rst_at);
            @(negedge clk);
            if (do_rst && c == rst_at) begin
                check("reset_outputs_zero",
                      {23'd0, bit_strobe, data_valid, framing_error, busy, data_out}, 32'd0);
            end
        end
        rst = 0;
    endtask

    task automatic send_frame(input logic [DB-1:0] dat, input logic stop, input int rst_bit);
        send_bit(1'b0, 0);
        for (int i = 0; i < DB; i++) send_bit(dat[i], i == rst_bit);
        send_bit(stop, 0);
    endtask

    task automatic hold(input logic level, input int ticks);
        rx_serial = level;
        repeat (ticks * tick_period) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int s_stb, s_val, s_fe, s_busy, s_vq, c0, bad;
        rst = 1;
        rx_serial = 1;
        repeat (5) @(negedge clk);
        rst = 0;
        check("reset_state", {23'd0, bit_strobe, data_valid, framing_error, busy, data_out}, 32'd0);
        hold(1, 4);

        // Frame 0x55, good stop
        s_stb = n_stb; s_val = n_val; s_fe = n_fe;
        stb_cyc.delete();
        c0 = cyc;
        send_frame(8'h55, 1'b1, -1);
        hold(1, 2 * OS);
        check("f55_strobes", n_stb - s_stb, 10);
        check("f55_valid", n_val - s_val, 1);
        check("f55_ferr", n_fe - s_fe, 0);
        check("f55_data", data_out, 8'h55);
        if (stb_cyc.size() == 10) begin
            bad = 0;
            for (int i = 1; i < 10; i++) if (stb_cyc[i] - stb_cyc[i-1] != 256) bad++;
            check("f55_spacing_bad", bad, 0);
            check_range("f55_first_delay", stb_cyc[0] - c0, 130, 147);
        end

        // Back-to-back 0xA3 then 0x0F
        s_stb = n_stb; s_vq = vq.size();
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        hold(1, 2 * OS);
        check("b2b_strobes", n_stb - s_stb, 20);
        check("b2b_valids", vq.size() - s_vq, 2);
        if (vq.size() - s_vq == 2) begin
            check("b2b_first", vq[s_vq], 8'hA3);
            check("b2b_second", vq[s_vq+1], 8'h0F);
        end

        // Short low glitch
        s_stb = n_stb; s_val = n_val; s_fe = n_fe; s_busy = n_busy;
        hold(0, 4);
        hold(1, 20);
        check("glitch_strobes", n_stb - s_stb, 0);
        check("glitch_valid_err", (n_val - s_val) + (n_fe - s_fe), 0);
        check("glitch_busy_cycles", n_busy - s_busy, 128);

        // Framing error with long break, then 0x81
        s_stb = n_stb; s_val = n_val; s_fe = n_fe;
        send_frame(8'h3C, 1'b0, -1);
        hold(0, 40);
        hold(1, 2 * OS);
        check("break_ferr", n_fe - s_fe, 1);
        check("break_valid", n_val - s_val, 0);
        check("break_strobes", n_stb - s_stb, 10);
        check("break_data_held", data_out, 8'h0F);
        s_stb = n_stb; s_val = n_val;
        send_frame(8'h81, 1'b1, -1);
        hold(1, 2 * OS);
        check("after_break_valid", n_val - s_val, 1);
        check("after_break_data", data_out, 8'h81);
        check("after_break_strobes", n_stb - s_stb, 10);

        // Reset during bit 4 of 0xFF, then 0x12
        s_val = n_val; s_fe = n_fe;
        send_frame(8'hFF, 1'b1, 4);
        hold(1, 2 * OS);
        check("rst_frame_valid", n_val - s_val, 0);
        check("rst_frame_ferr", n_fe - s_fe, 0);
        check("rst_frame_data", data_out, 8'h00);
        s_stb = n_stb; s_val = n_val;
        send_frame(8'h12, 1'b1, -1);
        hold(1, 2 * OS);
        check("post_rst_valid", n_val - s_val, 1);
        check("post_rst_data", data_out, 8'h12);
        check("post_rst_strobes", n_stb - s_stb, 10);

        // Randomised frames, glitches and tick periods against the model
        for (int it = 0; it < 20; it++) begin
            logic [DB-1:0] dat;
            logic          stp;
            int            gap;
            tick_period = $urandom_range(1, 6);
            dat = DB'($urandom);
            stp = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 4) == 0) begin
                hold(0, $urandom_range(1, 5));
                hold(1, $urandom_range(10, 20));
            end
            send_frame(dat, stp, -1);
            gap = $urandom_range(stp ? 0 : 1, 2);
            hold(1, gap * OS);
        end
        hold(1, 2 * OS);
        wait_idle("random_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
